// File: rtl/pf_lanectrl_dly_seq_pkg.sv
// -----------------------------------------------------------------------------
// pf_lanectrl_dly_pkg
//   Shared encodings for the DQS delay-line sequencer: requester op codes,
//   line select values, sequencer FSM states and the internal timer width.
// -----------------------------------------------------------------------------
package pf_lanectrl_dly_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_NOP  = 2'b11
  } op_e;

  localparam logic LINE_RX = 1'b0;
  localparam logic LINE_TX = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SETUP,
    ST_PULSE,
    ST_GAP,
    ST_PST,
    ST_DONE
  } state_e;

  // Width of the shared PRE/GAP/PST cycle timer.
  localparam int CNT_W = 8;

endpackage

// File: rtl/pf_lanectrl_dly_seq_if.sv
// -----------------------------------------------------------------------------
// pf_lanectrl_dly_seq_if
//   Requester-side bus of the delay-line sequencer, two requesters wide
//   (0 = training engine, 1 = VT tracker).
//   REQ_VALID/REQ_READY  per-requester command handshake
//   REQ_LINE             0 = RX, 1 = TX
//   REQ_OP               00 LOAD, 01 INC, 10 DEC, 11 NOP
//   REQ_STEPS            step count (ignored for LOAD)
//   DONE / DONE_ERR      one-cycle completion pulse to owner, error qualifier
//   master = requesters, slave = sequencer.
// -----------------------------------------------------------------------------
interface pf_lanectrl_dly_seq_if #(
  parameter int TAP_W = 8
);
  logic [1:0]            REQ_VALID;
  logic [1:0]            REQ_READY;
  logic [1:0]            REQ_LINE;
  logic [1:0][1:0]       REQ_OP;
  logic [1:0][TAP_W-1:0] REQ_STEPS;
  logic [1:0]            DONE;
  logic                  DONE_ERR;

  modport master (
    output REQ_VALID, REQ_LINE, REQ_OP, REQ_STEPS,
    input  REQ_READY, DONE, DONE_ERR
  );

  modport slave (
    input  REQ_VALID, REQ_LINE, REQ_OP, REQ_STEPS,
    output REQ_READY, DONE, DONE_ERR
  );
endinterface

// File: rtl/pf_lanectrl_dly_seq_rr_arb2.sv
// -----------------------------------------------------------------------------
// pf_lanectrl_rr_arb2
//   Two-way round-robin arbiter. The pointer favours one requester; on
//   advance it moves past the current winner.
//   clk_i, rst_ni  clock, asynchronous active-low reset (pointer favours 0)
//   valid_i        request vector
//   advance_i      grant consumed this cycle
//   grant_o        one-hot grant or 0 (combinational)
// -----------------------------------------------------------------------------
module pf_lanectrl_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] valid_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    grant_o = 2'b00;
    if (ptr_q == 1'b0) begin
      if (valid_i[0])      grant_o = 2'b01;
      else if (valid_i[1]) grant_o = 2'b10;
    end else begin
      if (valid_i[1])      grant_o = 2'b10;
      else if (valid_i[0]) grant_o = 2'b01;
    end
    ptr_d = ptr_q;
    // Winner 0 hands priority to 1 and vice versa.
    if (advance_i) ptr_d = grant_o[0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/pf_lanectrl_dly_seq.sv
// -----------------------------------------------------------------------------
// pf_lanectrl_dly_seq
//   Sequences tap LOAD/INC/DEC commands from two requesters onto one lane
//   controller's RX/TX DQS delay lines. Commands are granted round-robin,
//   optionally bracketed by HS_IO_CLK_PAUSE, and issued as timed
//   DELAY_LINE_LOAD/MOVE pulses. Tap positions are tracked per line and
//   range violations abort the command with DONE_ERR.
// Ports
//   FAB_CLK, RESET_N         fabric clock, asynchronous active-low reset
//   req_if (slave)           requester handshake, DONE/DONE_ERR
//   RX_TAP, TX_TAP           tracked tap positions
//   DELAY_LINE_SEL/LOAD/DIRECTION/MOVE, HS_IO_CLK_PAUSE  to lane controller
//   RX/TX_DELAY_LINE_OUT_OF_RANGE                        from lane controller
// Configuration
//   LANECTRL_DLY_SEQ_PAUSE_EN  defined: PRE/PST pause bracketing enabled.
//                              undefined: pause tied 0, PRE/PST take 0 cycles.
// -----------------------------------------------------------------------------
module pf_lanectrl_dly_seq
  import pf_lanectrl_dly_pkg::*;
#(
  parameter int TAP_W     = 8,
  parameter int MAX_TAP   = 255,
  parameter int INIT_TAP  = 1,
  parameter int MOVE_GAP  = 4,
  parameter int PAUSE_PRE = 2,
  parameter int PAUSE_PST = 2
) (
  input  logic                 FAB_CLK,
  input  logic                 RESET_N,
  pf_lanectrl_dly_seq_if.slave req_if,
  output logic [TAP_W-1:0]     RX_TAP,
  output logic [TAP_W-1:0]     TX_TAP,
  output logic                 DELAY_LINE_SEL,
  output logic                 DELAY_LINE_LOAD,
  output logic                 DELAY_LINE_DIRECTION,
  output logic                 DELAY_LINE_MOVE,
  output logic                 HS_IO_CLK_PAUSE,
  input  logic                 RX_DELAY_LINE_OUT_OF_RANGE,
  input  logic                 TX_DELAY_LINE_OUT_OF_RANGE
);

`ifdef LANECTRL_DLY_SEQ_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  localparam int PRE_CYC = PAUSE_EN ? PAUSE_PRE : 0;
  localparam int PST_CYC = PAUSE_EN ? PAUSE_PST : 0;
  localparam logic [CNT_W-1:0] PRE_LD = CNT_W'((PRE_CYC > 0) ? PRE_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] PST_LD = CNT_W'((PST_CYC > 0) ? PST_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(MOVE_GAP - 1);

  state_e             state_q;
  logic               armed_q;
  logic               owner_q;
  op_e                op_q;
  logic [TAP_W-1:0]   rem_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;
  logic [TAP_W-1:0]   rx_tap_q, tx_tap_q;
  logic               pause_q, sel_q, dir_q, load_q, move_q;
  logic [1:0]         done_q;
  logic               done_err_q;

  logic [1:0]         grant, ready;
  logic               win, acc_line;
  op_e                acc_op;
  logic [TAP_W-1:0]   acc_steps, tap_sel, tap_step;
  logic               setup_err, oor_sel;

  pf_lanectrl_rr_arb2 u_arb (
    .clk_i     (FAB_CLK),
    .rst_ni    (RESET_N),
    .valid_i   (req_if.REQ_VALID),
    .advance_i (|ready),
    .grant_o   (grant)
  );

  // armed_q keeps READY low while reset is asserted and on the first cycle out.
  assign ready     = (armed_q && state_q == ST_IDLE) ? grant : 2'b00;
  assign win       = ready[1];
  assign acc_line  = req_if.REQ_LINE[win];
  assign acc_op    = op_e'(req_if.REQ_OP[win]);
  assign acc_steps = req_if.REQ_STEPS[win];

  assign tap_sel   = sel_q ? tx_tap_q : rx_tap_q;
  assign tap_step  = (op_q == OP_LOAD) ? TAP_W'(INIT_TAP) :
                     (op_q == OP_INC)  ? tap_sel + TAP_W'(1) : tap_sel - TAP_W'(1);
  // Refuse a move that would leave the legal tap range.
  assign setup_err = (op_q == OP_INC && tap_sel == TAP_W'(MAX_TAP)) ||
                     (op_q == OP_DEC && tap_sel == '0);
  assign oor_sel   = sel_q ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;

  always_ff @(posedge FAB_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      armed_q    <= 1'b0;
      owner_q    <= 1'b0;
      op_q       <= OP_NOP;
      rem_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      rx_tap_q   <= TAP_W'(INIT_TAP);
      tx_tap_q   <= TAP_W'(INIT_TAP);
      pause_q    <= 1'b0;
      sel_q      <= 1'b0;
      dir_q      <= 1'b0;
      load_q     <= 1'b0;
      move_q     <= 1'b0;
      done_q     <= 2'b00;
      done_err_q <= 1'b0;
    end else begin
      armed_q    <= 1'b1;
      load_q     <= 1'b0;
      move_q     <= 1'b0;
      done_q     <= 2'b00;
      done_err_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: if (|ready) begin
          owner_q <= win;
          op_q    <= acc_op;
          rem_q   <= (acc_op == OP_LOAD) ? TAP_W'(1) : acc_steps;
          if (acc_op == OP_NOP || (acc_op != OP_LOAD && acc_steps == '0)) begin
            // Nothing to move: complete without touching the lane.
            state_q     <= ST_DONE;
            done_q[win] <= 1'b1;
          end else begin
            sel_q   <= acc_line;
            dir_q   <= (acc_op == OP_INC);
            pause_q <= PAUSE_EN;
            if (PRE_CYC != 0) begin
              state_q <= ST_PRE;
              cnt_q   <= PRE_LD;
            end else begin
              state_q <= ST_SETUP;
            end
          end
        end
        ST_PRE: begin
          if (cnt_q == '0) state_q <= ST_SETUP;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        ST_SETUP: begin
          if (setup_err) begin
            if (PST_CYC != 0) begin
              state_q <= ST_PST;
              cnt_q   <= PST_LD;
              err_q   <= 1'b1;
            end else begin
              state_q         <= ST_DONE;
              pause_q         <= 1'b0;
              done_q[owner_q] <= 1'b1;
              done_err_q      <= 1'b1;
            end
          end else begin
            state_q <= ST_PULSE;
            load_q  <= (op_q == OP_LOAD);
            move_q  <= (op_q != OP_LOAD);
          end
        end
        ST_PULSE: begin
          if (sel_q) tx_tap_q <= tap_step;
          else       rx_tap_q <= tap_step;
          state_q <= ST_GAP;
          cnt_q   <= GAP_LD;
        end
        ST_GAP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            rem_q <= rem_q - TAP_W'(1);
            if (!oor_sel && rem_q != TAP_W'(1)) begin
              state_q <= ST_SETUP;
            end else if (PST_CYC != 0) begin
              state_q <= ST_PST;
              cnt_q   <= PST_LD;
              err_q   <= oor_sel;
            end else begin
              state_q         <= ST_DONE;
              pause_q         <= 1'b0;
              done_q[owner_q] <= 1'b1;
              done_err_q      <= oor_sel;
            end
          end
        end
        ST_PST: begin
          if (cnt_q == '0) begin
            state_q         <= ST_DONE;
            pause_q         <= 1'b0;
            done_q[owner_q] <= 1'b1;
            done_err_q      <= err_q;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          err_q   <= 1'b0;
          sel_q   <= 1'b0;
          dir_q   <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_if.REQ_READY     = ready;
  assign req_if.DONE          = done_q;
  assign req_if.DONE_ERR      = done_err_q;
  assign RX_TAP               = rx_tap_q;
  assign TX_TAP               = tx_tap_q;
  assign DELAY_LINE_SEL       = sel_q;
  assign DELAY_LINE_LOAD      = load_q;
  assign DELAY_LINE_DIRECTION = dir_q;
  assign DELAY_LINE_MOVE      = move_q;
  assign HS_IO_CLK_PAUSE      = pause_q;

endmodule

// File: tb/tb_pf_lanectrl_dly_seq.sv
module tb_pf_lanectrl_dly_seq;

  localparam int TAP_W     = 8;
  localparam int MAX_TAP   = 255;
  localparam int INIT_TAP  = 1;
  localparam int MOVE_GAP  = 4;
  localparam int PAUSE_PRE = 2;
  localparam int PAUSE_PST = 2;
`ifdef LANECTRL_DLY_SEQ_PAUSE_EN
  localparam int PE = 1;
`else
  localparam int PE = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_oor = 1'b0, tx_oor = 1'b0;
  logic [TAP_W-1:0] rx_tap, tx_tap;
  logic sel, ld, dir, mv, pause;

  pf_lanectrl_dly_seq_if #(.TAP_W(TAP_W)) bus ();

  pf_lanectrl_dly_seq #(
    .TAP_W(TAP_W), .MAX_TAP(MAX_TAP), .INIT_TAP(INIT_TAP),
    .MOVE_GAP(MOVE_GAP), .PAUSE_PRE(PAUSE_PRE), .PAUSE_PST(PAUSE_PST)
  ) dut (
    .FAB_CLK                    (clk),
    .RESET_N                    (rst_n),
    .req_if                     (bus),
    .RX_TAP                     (rx_tap),
    .TX_TAP                     (tx_tap),
    .DELAY_LINE_SEL             (sel),
    .DELAY_LINE_LOAD            (ld),
    .DELAY_LINE_DIRECTION       (dir),
    .DELAY_LINE_MOVE            (mv),
    .HS_IO_CLK_PAUSE            (pause),
    .RX_DELAY_LINE_OUT_OF_RANGE (rx_oor),
    .TX_DELAY_LINE_OUT_OF_RANGE (tx_oor)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int owner;
    bit err;
    int pulses;
    bit is_load;
    bit line;
    bit dir;
    int rx;
    int tx;
    int done_cyc;
  } exp_t;

  exp_t sbq[$];
  int   acc_log[$];
  int   mrx = INIT_TAP, mtx = INIT_TAP, mptr = 0;
  int   cur_pulses = 0, last_pulse = 0, done_cnt = 0;
  exp_t mon_e;
  logic [1:0] mon_ex, mon_v;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: round-robin grant model, pulse checks, scoreboard pop on DONE.
  always @(negedge clk) begin
    if (rst_n) begin
      if (|bus.REQ_READY) begin
        mon_v = bus.REQ_VALID;
        if (mptr == 0) mon_ex = mon_v[0] ? 2'b01 : (mon_v[1] ? 2'b10 : 2'b00);
        else           mon_ex = mon_v[1] ? 2'b10 : (mon_v[0] ? 2'b01 : 2'b00);
        chk("rr_grant", bus.REQ_READY, mon_ex);
        mptr = bus.REQ_READY[0] ? 1 : 0;
      end
      if (ld || mv) begin
        if (sbq.size() == 0) begin
          chk("pulse_unexpected", {ld, mv}, 2'b00);
        end else begin
          mon_e = sbq[0];
          chk("pulse_kind", {ld, mv}, mon_e.is_load ? 2'b10 : 2'b01);
          chk("pulse_sel", sel, mon_e.line);
          if (mv) chk("pulse_dir", dir, mon_e.dir);
          chk("pulse_pause", pause, PE);
          if (cur_pulses > 0) chk("pulse_spacing", cyc - last_pulse, 2 + MOVE_GAP);
          cur_pulses++;
          last_pulse = cyc;
        end
      end
      if (|bus.DONE) begin
        if (sbq.size() == 0) begin
          chk("done_unexpected", bus.DONE, 2'b00);
        end else begin
          mon_e = sbq.pop_front();
          chk("done_owner", bus.DONE, (mon_e.owner == 1) ? 2'b10 : 2'b01);
          chk("done_err", bus.DONE_ERR, mon_e.err);
          chk("done_pulses", cur_pulses, mon_e.pulses);
          chk("done_rx_tap", rx_tap, mon_e.rx);
          chk("done_tx_tap", tx_tap, mon_e.tx);
          chk("done_latency", cyc, mon_e.done_cyc);
          chk("done_pause_low", pause, 1'b0);
        end
        cur_pulses = 0;
        done_cnt++;
      end
    end
  end

  // Drive one command; on acceptance push the modelled outcome.
  task automatic send(input int r, input int line, input int op, input int steps, input int oor_after);
    exp_t e;
    int   tap, body, lat;
    bit   ok;
    ok = 1'b0;
    @(posedge clk); #1;
    bus.REQ_LINE[r]  = line[0];
    bus.REQ_OP[r]    = op[1:0];
    bus.REQ_STEPS[r] = steps[TAP_W-1:0];
    bus.REQ_VALID[r] = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.REQ_READY[r]) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      e.owner = r; e.line = line[0]; e.dir = (op == 1); e.is_load = (op == 0);
      e.err = 1'b0; e.pulses = 0;
      tap = line[0] ? mtx : mrx;
      if (op == 3 || (op != 0 && steps == 0)) begin
        lat = 2;
      end else begin
        body = 0;
        if (op == 0) begin
          tap = INIT_TAP; e.pulses = 1; body = 2 + MOVE_GAP;
        end else begin
          for (int i = 0; i < steps; i++) begin
            if ((op == 1 && tap == MAX_TAP) || (op == 2 && tap == 0)) begin
              e.err = 1'b1; body += 1;
              break;
            end
            tap += (op == 1) ? 1 : -1;
            e.pulses++;
            body += 2 + MOVE_GAP;
            if (oor_after != 0 && e.pulses == oor_after) begin
              e.err = 1'b1;
              break;
            end
          end
        end
        lat = 1 + PE * PAUSE_PRE + body + PE * PAUSE_PST + 1;
      end
      if (line[0]) mtx = tap; else mrx = tap;
      e.rx = mrx; e.tx = mtx;
      e.done_cyc = cyc + lat - 1;
      sbq.push_back(e);
      acc_log.push_back(r);
    end else begin
      chk("ready_timeout", bus.REQ_READY[r], 1'b1);
    end
    @(posedge clk); #1;
    bus.REQ_VALID[r] = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk("done_count", done_cnt, target);
  endtask

  initial begin
    int n;
    bus.REQ_VALID = 2'b11;
    bus.REQ_LINE  = 2'b00;
    bus.REQ_OP    = '0;
    bus.REQ_STEPS = '0;

    // Reset state, with both requesters asserting valid.
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.REQ_READY, 2'b00);
    chk("rst_done", bus.DONE, 2'b00);
    chk("rst_outs", {sel, ld, dir, mv, pause, bus.DONE_ERR}, 6'b0);
    chk("rst_rx_tap", rx_tap, INIT_TAP);
    chk("rst_tx_tap", tx_tap, INIT_TAP);
    bus.REQ_VALID = 2'b00;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Req0 RX INC 3: RX 1 -> 4.
    send(0, 0, 1, 3, 0);
    wait_done(1, 200);

    // Both requesters busy: 4 commands each, grants must alternate.
    fork
      begin
        for (int i = 0; i < 4; i++) send(0, 0, (i == 3) ? 3 : 1, 1, 0);
      end
      begin
        for (int j = 0; j < 4; j++) send(1, 1, (j % 2 == 0) ? 1 : 2, 1, 0);
      end
    join
    wait_done(9, 400);
    for (int i = 1; i < acc_log.size(); i++) chk("rr_alternate", acc_log[i], 1 - acc_log[i-1]);
    acc_log.delete();

    // Req1 TX DEC 5 at tap 1: one move then range abort.
    send(1, 1, 2, 5, 0);
    wait_done(10, 200);
    chk("tx_at_zero", tx_tap, 0);

    // RX INC 4 with out-of-range raised after the 2nd pulse.
    send(0, 0, 1, 4, 2);
    n = 0;
    while (cur_pulses < 2 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    rx_oor = 1'b1;
    wait_done(11, 200);
    rx_oor = 1'b0;
    chk("oor_rx_tap", rx_tap, 9);
    chk("oor_pause_released", pause, 1'b0);

    // LOAD from tap 9 back to INIT_TAP; steps field ignored.
    send(0, 0, 0, 37, 0);
    wait_done(12, 200);

    // INC with zero steps: immediate DONE, no pulse, no error.
    send(1, 1, 1, 0, 0);
    wait_done(13, 50);

    // DEC at tap 0: pre-check abort with no pulse.
    send(0, 1, 2, 2, 0);
    wait_done(14, 50);

    // Saturating INC: 254 moves to MAX_TAP then abort.
    send(1, 0, 1, 255, 0);
    wait_done(15, 2500);
    chk("sat_rx_tap", rx_tap, MAX_TAP);

    // Reset in the middle of a GAP.
    send(0, 0, 2, 3, 0);
    n = 0;
    while (cur_pulses < 1 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {sel, ld, dir, mv, pause, bus.DONE_ERR}, 6'b0);
    chk("midrst_done", bus.DONE, 2'b00);
    chk("midrst_rx_tap", rx_tap, INIT_TAP);
    chk("midrst_tx_tap", tx_tap, INIT_TAP);
    sbq.delete();
    mrx = INIT_TAP; mtx = INIT_TAP; mptr = 0; cur_pulses = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (|bus.DONE) n++;
    end
    chk("midrst_no_done", n, 0);
    chk("midrst_rx_hold", rx_tap, INIT_TAP);

    // NOP after reset: immediate completion to req1.
    send(1, 1, 3, 9, 0);
    wait_done(16, 50);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
